// File: rtl/crc_bit_feeder.sv
// Byte-to-bit feeder for a serial CRC-32 engine: accepts framed bytes, shifts them
// out one bit per clock, clears the engine per frame and reports CRC and length.
module crc_bit_feeder #(
    parameter bit MSB_FIRST = 1'b1,
    parameter int LEN_W     = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [7:0]       s_data,
    input  logic             s_valid,
    input  logic             s_last,
    output logic             s_ready,
    output logic             crc_clr,
    output logic             crc_en,
    output logic             crc_din,
    input  logic [31:0]      crc_in,
    output logic [31:0]      crc_result,
    output logic [LEN_W-1:0] frame_len,
    output logic             crc_valid,
    output logic             busy
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    logic [7:0]         sr_q, sr_d;
    logic               last_q, last_d;
    logic               frame_open_q, frame_open_d;
    logic [LEN_W-1:0]   len_cnt_q, len_cnt_d;
    logic [31:0]        crc_result_q, crc_result_d;
    logic [LEN_W-1:0]   frame_len_q, frame_len_d;
    logic               crc_valid_q, crc_valid_d;
    logic               last_bit_s;
    logic               ready_s;
    logic               acc_s;

    assign last_bit_s = (state_q == ST_SHIFT) && (bit_cnt_q == 3'd7);
    assign ready_s    = (state_q == ST_IDLE) || last_bit_s;
    assign acc_s      = s_valid & ready_s;

    // Next-state logic: FSM, shift register, frame tracking and result capture
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        sr_d         = sr_q;
        last_d       = last_q;
        frame_open_d = frame_open_q;
        len_cnt_d    = len_cnt_q;
        crc_result_d = crc_result_q;
        frame_len_d  = frame_len_q;
        crc_valid_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (acc_s) begin
                    sr_d      = s_data;
                    bit_cnt_d = 3'd0;
                    last_d    = s_last;
                    state_d   = ST_SHIFT;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                bit_cnt_d = bit_cnt_q + 3'd1;
                sr_d      = MSB_FIRST ? {sr_q[6:0], 1'b0} : {1'b0, sr_q[7:1]};
                if (last_bit_s && acc_s) begin
                    sr_d      = s_data;
                    bit_cnt_d = 3'd0;
                    last_d    = s_last;
                end else if (last_bit_s) begin
                    state_d   = ST_IDLE;
                end else begin
                    state_d   = ST_SHIFT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A new frame restarts the count at 1; the count sticks at all-ones
        if (acc_s) begin
            frame_open_d = ~s_last;
            if (!frame_open_q) begin
                len_cnt_d = LEN_W'(1);
            end else if (len_cnt_q != {LEN_W{1'b1}}) begin
                len_cnt_d = len_cnt_q + LEN_W'(1);
            end else begin
                len_cnt_d = len_cnt_q;
            end
        end else begin
            frame_open_d = frame_open_q;
        end

        // crc_in is the engine's next-state value, so it already includes the final bit
        if (last_bit_s && last_q) begin
            crc_result_d = crc_in;
            frame_len_d  = len_cnt_q;
            crc_valid_d  = 1'b1;
        end else begin
            crc_valid_d  = 1'b0;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= 3'd0;
            sr_q         <= 8'h00;
            last_q       <= 1'b0;
            frame_open_q <= 1'b0;
            len_cnt_q    <= {LEN_W{1'b0}};
            crc_result_q <= 32'h0000_0000;
            frame_len_q  <= {LEN_W{1'b0}};
            crc_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            sr_q         <= sr_d;
            last_q       <= last_d;
            frame_open_q <= frame_open_d;
            len_cnt_q    <= len_cnt_d;
            crc_result_q <= crc_result_d;
            frame_len_q  <= frame_len_d;
            crc_valid_q  <= crc_valid_d;
        end
    end

    assign s_ready    = ready_s;
    assign crc_clr    = acc_s & ~frame_open_q;
    assign crc_en     = (state_q == ST_SHIFT);
    assign crc_din    = (state_q == ST_SHIFT) & (MSB_FIRST ? sr_q[7] : sr_q[0]);
    assign busy       = (state_q == ST_SHIFT);
    assign crc_result = crc_result_q;
    assign frame_len  = frame_len_q;
    assign crc_valid  = crc_valid_q;

endmodule

// File: tb/tb_crc_bit_feeder.sv
// Directed bench for crc_bit_feeder: three instances (MSB-first, LSB-first, LEN_W=2)
// share one stimulus stream, each driving a behavioural serial CRC-32 engine.
module tb_crc_bit_feeder;

    localparam logic [31:0] POLY = 32'h04C1_1DB7;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  s_data = 8'h00;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    logic        a_ready, a_clr, a_en, a_din, a_valid, a_busy;
    logic [31:0] a_in, a_res, eng_a;
    logic [15:0] a_len;
    logic        b_ready, b_clr, b_en, b_din, b_valid, b_busy;
    logic [31:0] b_in, b_res, eng_b;
    logic [15:0] b_len;
    logic        c_ready, c_clr, c_en, c_din, c_valid, c_busy;
    logic [31:0] c_in, c_res, eng_c;
    logic [1:0]  c_len;

    typedef struct {
        logic [31:0] crc;
        logic [15:0] len;
        int          cyc;
    } res_t;
    res_t qa[$];
    res_t qb[$];
    res_t qc[$];
    int   en_run = 0;
    int   en_max = 0;

    typedef struct {
        logic [7:0]  data;
        logic        lsb;
        logic [31:0] exp_crc;
    } vec_t;
    vec_t vecs[7];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic d);
        crc_step = {c[30:0], 1'b0} ^ ((c[31] ^ d) ? POLY : 32'h0000_0000);
    endfunction

    assign a_in = a_en ? crc_step(eng_a, a_din) : eng_a;
    assign b_in = b_en ? crc_step(eng_b, b_din) : eng_b;
    assign c_in = c_en ? crc_step(eng_c, c_din) : eng_c;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            eng_a <= 32'h0; eng_b <= 32'h0; eng_c <= 32'h0;
        end else begin
            eng_a <= a_clr ? 32'h0 : (a_en ? a_in : eng_a);
            eng_b <= b_clr ? 32'h0 : (b_en ? b_in : eng_b);
            eng_c <= c_clr ? 32'h0 : (c_en ? c_in : eng_c);
        end
    end

    crc_bit_feeder dut_a (
        .clk(clk), .reset_n(reset_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(a_ready), .crc_clr(a_clr), .crc_en(a_en), .crc_din(a_din), .crc_in(a_in),
        .crc_result(a_res), .frame_len(a_len), .crc_valid(a_valid), .busy(a_busy)
    );
    crc_bit_feeder #(.MSB_FIRST(1'b0)) dut_b (
        .clk(clk), .reset_n(reset_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(b_ready), .crc_clr(b_clr), .crc_en(b_en), .crc_din(b_din), .crc_in(b_in),
        .crc_result(b_res), .frame_len(b_len), .crc_valid(b_valid), .busy(b_busy)
    );
    crc_bit_feeder #(.LEN_W(2)) dut_c (
        .clk(clk), .reset_n(reset_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(c_ready), .crc_clr(c_clr), .crc_en(c_en), .crc_din(c_din), .crc_in(c_in),
        .crc_result(c_res), .frame_len(c_len), .crc_valid(c_valid), .busy(c_busy)
    );

    always @(negedge clk) begin
        res_t r;
        if (a_valid) begin r.crc = a_res; r.len = a_len; r.cyc = cyc; qa.push_back(r); end
        if (b_valid) begin r.crc = b_res; r.len = b_len; r.cyc = cyc; qb.push_back(r); end
        if (c_valid) begin r.crc = c_res; r.len = {14'd0, c_len}; r.cyc = cyc; qc.push_back(r); end
        en_run = a_en ? en_run + 1 : 0;
        if (en_run > en_max) en_max = en_run;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_q();
        qa.delete(); qb.delete(); qc.delete();
    endtask

    // Holds s_valid until accepted; returns at the negedge after the accept edge
    task automatic send_byte(input logic [7:0] d, input logic l,
                             output logic clr, output logic en, output int tacc);
        clr = 1'b0; en = 1'b0; tacc = -1;
        s_valid = 1'b1; s_data = d; s_last = l;
        for (int n = 0; n < 30; n++) begin
            #1;
            if (a_ready) begin
                clr = a_clr; en = a_en; tacc = cyc;
                @(negedge clk);
                return;
            end
            @(negedge clk);
        end
        total++; bad++;
        $display("FAIL send_byte: accept timeout got no s_ready expected s_ready within 30 cycles");
    endtask

    initial begin
        logic        clr, en;
        int          t0, t1, ens;
        logic [7:0]  dseq;

        vecs[0] = '{8'h00, 1'b0, 32'h0000_0000};
        vecs[1] = '{8'h01, 1'b0, 32'h04C1_1DB7};
        vecs[2] = '{8'h02, 1'b0, 32'h0982_3B6E};
        vecs[3] = '{8'h03, 1'b0, 32'h0D43_26D9};
        vecs[4] = '{8'h04, 1'b0, 32'h1304_76DC};
        vecs[5] = '{8'h80, 1'b1, 32'h04C1_1DB7};
        vecs[6] = '{8'hC0, 1'b1, 32'h0D43_26D9};

        // reset state
        #2;
        chk("rst_s_ready", {31'd0, a_ready}, 32'd1);
        chk("rst_outs", {a_clr, a_en, a_din, a_valid, a_busy}, 32'd0);
        chk("rst_result", a_res, 32'd0);
        chk("rst_len", {16'd0, a_len}, 32'd0);
        idle(2);
        reset_n = 1'b1;
        idle(1);

        // single byte 0x01, MSB first: bit sequence and latency
        clear_q();
        send_byte(8'h01, 1'b1, clr, en, t0);
        s_valid = 1'b0;
        dseq = 8'h00; ens = 0;
        for (int i = 0; i < 8; i++) begin
            dseq = {dseq[6:0], a_din};
            ens += a_en ? 1 : 0;
            @(negedge clk);
        end
        idle(3);
        chk("t1_clr", {31'd0, clr}, 32'd1);
        chk("t1_din_seq", {24'd0, dseq}, 32'h01);
        chk("t1_en_cycles", ens, 32'd8);
        chk("t1_nvalid", qa.size(), 32'd1);
        if (qa.size() == 1) begin
            chk("t1_crc", qa[0].crc, POLY);
            chk("t1_len", {16'd0, qa[0].len}, 32'd1);
            chk("t1_latency", qa[0].cyc - t0, 32'd9);
        end
        chk("t1_idle_en", {31'd0, a_en}, 32'd0);

        // table of single-byte frames
        for (int v = 0; v < 7; v++) begin
            res_t r;
            clear_q();
            send_byte(vecs[v].data, 1'b1, clr, en, t0);
            s_valid = 1'b0;
            idle(12);
            chk($sformatf("vec%0d_clr", v), {31'd0, clr}, 32'd1);
            if (vecs[v].lsb) begin
                chk($sformatf("vec%0d_nvalid", v), qb.size(), 32'd1);
                if (qb.size() == 1) r = qb[0]; else r = '{32'hDEAD_BEEF, 16'hFFFF, -1};
            end else begin
                chk($sformatf("vec%0d_nvalid", v), qa.size(), 32'd1);
                if (qa.size() == 1) r = qa[0]; else r = '{32'hDEAD_BEEF, 16'hFFFF, -1};
            end
            chk($sformatf("vec%0d_crc", v), r.crc, vecs[v].exp_crc);
            chk($sformatf("vec%0d_len", v), {16'd0, r.len}, 32'd1);
            chk($sformatf("vec%0d_latency", v), r.cyc - t0, 32'd9);
        end

        // four 0x00 bytes, continuous valid
        clear_q(); en_max = 0;
        send_byte(8'h00, 1'b0, clr, en, t0);
        send_byte(8'h00, 1'b0, clr, en, t1);
        chk("t4_gap", t1 - t0, 32'd8);
        send_byte(8'h00, 1'b0, clr, en, t1);
        send_byte(8'h00, 1'b1, clr, en, t1);
        chk("t4_mid_clr", {31'd0, clr}, 32'd0);
        s_valid = 1'b0;
        idle(12);
        chk("t4_en_run", en_max, 32'd32);
        chk("t4_nvalid", qa.size(), 32'd1);
        if (qa.size() == 1) begin
            chk("t4_crc", qa[0].crc, 32'h0);
            chk("t4_len", {16'd0, qa[0].len}, 32'd4);
            chk("t4_latency", qa[0].cyc - t0, 32'd33);
        end

        // back-to-back single-byte frames: overlap of en and clr
        clear_q();
        send_byte(8'h01, 1'b1, clr, en, t0);
        send_byte(8'h01, 1'b1, clr, en, t1);
        s_valid = 1'b0;
        idle(12);
        chk("bb_overlap_clr", {31'd0, clr}, 32'd1);
        chk("bb_overlap_en", {31'd0, en}, 32'd1);
        chk("bb_nvalid", qa.size(), 32'd2);
        if (qa.size() == 2) begin
            chk("bb_crc0", qa[0].crc, POLY);
            chk("bb_crc1", qa[1].crc, POLY);
            chk("bb_len1", {16'd0, qa[1].len}, 32'd1);
            chk("bb_spacing", qa[1].cyc - qa[0].cyc, 32'd8);
        end

        // async reset at bit 4 of the second byte
        clear_q();
        send_byte(8'h00, 1'b0, clr, en, t0);
        send_byte(8'hFF, 1'b1, clr, en, t1);
        s_valid = 1'b0;
        idle(4);
        reset_n = 1'b0;
        #1;
        chk("mr_outs", {a_clr, a_en, a_din, a_valid, a_busy}, 32'd0);
        chk("mr_ready", {31'd0, a_ready}, 32'd1);
        chk("mr_result", a_res, 32'd0);
        chk("mr_len", {16'd0, a_len}, 32'd0);
        idle(2);
        reset_n = 1'b1;
        idle(12);
        chk("mr_no_valid", qa.size(), 32'd0);
        send_byte(8'h01, 1'b1, clr, en, t0);
        s_valid = 1'b0;
        idle(12);
        chk("mr_clr", {31'd0, clr}, 32'd1);
        chk("mr_nvalid", qa.size(), 32'd1);
        if (qa.size() == 1) begin
            chk("mr_crc", qa[0].crc, POLY);
            chk("mr_flen", {16'd0, qa[0].len}, 32'd1);
        end

        // five-byte frame: saturation with LEN_W=2
        clear_q();
        for (int i = 0; i < 5; i++) send_byte(8'h00, (i == 4), clr, en, t0);
        s_valid = 1'b0;
        idle(12);
        chk("sat_nvalid", qc.size(), 32'd1);
        if (qc.size() == 1) chk("sat_len2", {16'd0, qc[0].len}, 32'd3);
        if (qa.size() == 1) chk("sat_len16", {16'd0, qa[0].len}, 32'd5);
        else chk("sat_a_nvalid", qa.size(), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
